monostable_rr_sched: RTL

//  Shares one retriggerable monostable timer among N_REQ requesters.

---
 rtl/monostable_rr_sched.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/monostable_rr_sched.sv
// Purpose : round-robin sharing of one retriggerable monostable pulse timer among N_REQ requesters.
// Latency : grant, owner, q and busy rise on the same edge that arbitrates; q lasts max(period,1) clocks.
// Backpr. : none; requesters hold req until granted, and losers simply wait for a later IDLE cycle.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_req     per-requester request level
//   i_retrig  per-requester retrigger pulse; only the current owner's bit reloads the timer
//   i_abort   ends the running period on the next edge without a done pulse
//   i_period  pulse length in clocks, sampled at grant and at each accepted retrigger (0 acts as 1)
//   o_grant   one-hot owner while the timer runs, all-zero otherwise
//   o_owner   index of the current owner, or of the last owner while idle
//   o_q       monostable output
//   o_busy    timer running
//   o_done    one-cycle pulse to the owner on natural expiry only
module monostable_rr_sched #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 9,
  parameter int IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_retrig,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_period,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_owner,
  output logic             o_q,
  output logic             o_busy,
  output logic [N_REQ-1:0] o_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  // Registered state and outputs
  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IDX_W-1:0] r_owner;
  logic             r_q;
  logic             r_busy;
  logic [N_REQ-1:0] r_done;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_cnt;

  // Next-state values
  state_t           w_state_nxt;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [IDX_W-1:0] w_owner_nxt;
  logic             w_q_nxt;
  logic             w_busy_nxt;
  logic [N_REQ-1:0] w_done_nxt;
  logic [IDX_W-1:0] w_rr_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Arbitration helpers
  logic             w_any_req;
  logic [IDX_W-1:0] w_win;
  logic [N_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0] w_win_inc;
  logic [CNT_W-1:0] w_period_eff;
  logic             w_owner_retrig;

  assign w_any_req = |i_req;

  // A zero period would otherwise underflow the down-counter; run it as one clock.
  assign w_period_eff = (i_period == '0) ? CNT_W'(1) : i_period;

  // Only the owner's retrigger bit matters; everyone else is ignored.
  assign w_owner_retrig = i_retrig[r_owner];

  // Round-robin search: first asserted request at or after r_rr_ptr, wrapping.
  always_comb begin
    logic             v_found;
    logic [IDX_W-1:0] v_idx;
    w_win   = r_rr_ptr;
    v_found = 1'b0;
    v_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      v_idx = IDX_W'((int'(r_rr_ptr) + i) % N_REQ);
      if (!v_found && i_req[v_idx]) begin
        v_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  assign w_win_oh  = N_REQ'(1) << w_win;
  // Wrap explicitly so non-power-of-two N_REQ still cycles over valid indices.
  assign w_win_inc = (w_win == IDX_W'(N_REQ - 1)) ? '0 : (w_win + IDX_W'(1));

  // Next-state and output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_owner_nxt  = r_owner;
    w_q_nxt      = r_q;
    w_busy_nxt   = r_busy;
    w_done_nxt   = '0;
    w_rr_ptr_nxt = r_rr_ptr;
    w_cnt_nxt    = r_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = S_ACTIVE;
          w_grant_nxt  = w_win_oh;
          w_owner_nxt  = w_win;
          w_cnt_nxt    = w_period_eff;
          w_q_nxt      = 1'b1;
          w_busy_nxt   = 1'b1;
          w_rr_ptr_nxt = w_win_inc;
        end
      end

      S_ACTIVE: begin
        if (i_abort) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b0;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end else if (w_owner_retrig) begin
          // Reload beats expiry when both land on the same edge.
          w_cnt_nxt = w_period_eff;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt         = S_GAP;
          w_cnt_nxt           = '0;
          w_q_nxt             = 1'b0;
          w_grant_nxt         = '0;
          w_busy_nxt          = 1'b0;
          w_done_nxt[r_owner] = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_GAP: begin
        // Forces at least one low cycle on q between owners, even on a re-win.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_q_nxt     = 1'b0;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_q      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_q      <= w_q_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign o_grant = r_grant;
  assign o_owner = r_owner;
  assign o_q     = r_q;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule
